// File: rtl/game_input_arbiter.sv
// game_input_arbiter: merges human and AI button sources for the player controller,
// with per-bit synchronise+debounce, attract-mode handover and an idle timeout.
module game_input_arbiter #(
    parameter int NUM_SRC    = 3,
    parameter int DEB_COUNT  = 4,
    parameter int IDLE_TICKS = 600,
    localparam int SRC_W     = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               countdown_en,
    input  logic               game_tick,
    input  logic               force_ai,
    input  logic [NUM_SRC-1:0] src_present,
    input  logic [NUM_SRC-1:0] src_up,
    input  logic [NUM_SRC-1:0] src_down,
    input  logic [NUM_SRC-1:0] src_start,
    output logic               button_up,
    output logic               button_down,
    output logic               button_start,
    output logic               up_pulse,
    output logic [SRC_W-1:0]   active_src,
    output logic               ai_active
);
    localparam int AI = NUM_SRC - 1;
    localparam int H  = NUM_SRC - 1;
    localparam int IW = $clog2(IDLE_TICKS + 1);

    typedef enum logic {ATTRACT, HUMAN} state_t;

    state_t                 state, state_n;
    logic [H-1:0][2:0]      raw, s1, s2, deb, deb_q;
    logic [H-1:0][2:0][3:0] cnt;
    logic [SRC_W-1:0]       src_n, first;
    logic [2:0]             btn_n, act_deb, act_prev, ai_btn;
    logic                   act_present, hit;
    logic [IW-1:0]          idle, idle_n;
    logic                   unused_ai_present;

    // The AI is always considered present, so its presence bit is never read.
    assign unused_ai_present = src_present[AI];
    assign ai_btn            = {src_start[AI], src_down[AI], src_up[AI]};
    assign ai_active         = (state == ATTRACT);

    always_comb begin
        raw = '0;
        for (int i = 0; i < H; i++)
            raw[i] = {src_start[i], src_down[i], src_up[i]};
    end

    // Bit order per source is {start, down, up}.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= '0;
            s2    <= '0;
            deb   <= '0;
            deb_q <= '0;
            cnt   <= '0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            deb_q <= deb;
            if (countdown_en)
                for (int i = 0; i < H; i++)
                    for (int b = 0; b < 3; b++)
                        if (s2[i][b] == deb[i][b])
                            cnt[i][b] <= '0;
                        else if (cnt[i][b] == 4'(DEB_COUNT - 1)) begin
                            deb[i][b] <= s2[i][b];
                            cnt[i][b] <= '0;
                        end else
                            cnt[i][b] <= cnt[i][b] + 4'd1;
        end
    end

    // Descending scan so the lowest-index rising start wins.
    always_comb begin
        hit         = 1'b0;
        first       = SRC_W'(AI);
        act_deb     = '0;
        act_prev    = '0;
        act_present = 1'b0;
        for (int i = H - 1; i >= 0; i--) begin
            if (deb[i][2] && !deb_q[i][2] && src_present[i]) begin
                hit   = 1'b1;
                first = SRC_W'(i);
            end
            if (active_src == SRC_W'(i)) begin
                act_deb     = deb[i];
                act_prev    = deb_q[i];
                act_present = src_present[i];
            end
        end
    end

    always_comb begin
        state_n = state;
        src_n   = active_src;
        btn_n   = '0;
        idle_n  = '0;
        if (state == ATTRACT) begin
            btn_n = ai_btn;
            if (!force_ai && hit) begin
                state_n = HUMAN;
                src_n   = first;
                btn_n   = '0;
            end
        end else begin
            btn_n  = act_deb;
            idle_n = (act_deb != act_prev) ? '0 :
                     (game_tick && idle != IW'(IDLE_TICKS)) ? idle + 1'b1 : idle;
            if (force_ai || idle == IW'(IDLE_TICKS) || !act_present) begin
                state_n = ATTRACT;
                src_n   = SRC_W'(AI);
                btn_n   = '0;
                idle_n  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                                 <= ATTRACT;
            active_src                            <= SRC_W'(AI);
            {button_start, button_down, button_up} <= '0;
            up_pulse                              <= 1'b0;
            idle                                  <= '0;
        end else begin
            state                                 <= state_n;
            active_src                            <= src_n;
            {button_start, button_down, button_up} <= btn_n;
            up_pulse                              <= btn_n[0] & ~button_up;
            idle                                  <= idle_n;
        end
    end
endmodule
